// File: rtl/pipelined_adder_pkg.sv
// Shared constants and per-stage control record for pipelined_adder.
// The width-dependent part of the stage record (skew, partial sum) is built inside the top.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int num_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
    logic ovf;
  } stage_ctl_t;

endpackage

// File: rtl/pipelined_adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: one CHUNK-bit segment per stage, valid/ready on both sides.
// Define PIPELINED_ADDER_SAT_EN to saturate the sum on carry/overflow instead of wrapping.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CHUNK  = DEFAULT_CHUNK,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NSTAGES = num_stages(WIDTH, CHUNK);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
  end

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Operands ride along in full; stage k only consumes segment k of a/b.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t stage_q [NSTAGES];
  stage_t last_q;
  logic   adv;

  assign last_q   = stage_q[NSTAGES-1];
  assign adv      = !last_q.ctl.valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
    stage_t           stage_src;
    stage_t           stage_d;
    logic [CHUNK-1:0] seg_sum;
    logic             seg_cout;

    if (gi == 0) begin : g_head
      always_comb begin
        stage_src           = '0;
        stage_src.ctl.valid = in_valid;
        stage_src.ctl.carry = carry_in;
        stage_src.ctl.a_msb = input_1[WIDTH-1];
        stage_src.ctl.b_msb = input_2[WIDTH-1];
        stage_src.a         = input_1;
        stage_src.b         = input_2;
      end
    end else begin : g_body
      assign stage_src = stage_q[gi-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i   (stage_src.a[gi*CHUNK +: CHUNK]),
      .b_i   (stage_src.b[gi*CHUNK +: CHUNK]),
      .cin_i (stage_src.ctl.carry),
      .sum_o (seg_sum),
      .cout_o(seg_cout)
    );

    always_comb begin
      stage_d                      = stage_src;
      stage_d.s[gi*CHUNK +: CHUNK] = seg_sum;
      stage_d.ctl.carry            = seg_cout;
      stage_d.ctl.ovf              = 1'b0;
      // The final segment holds the sum MSB, so flags and saturation are resolved here.
      if (gi == NSTAGES - 1) begin
        stage_d.ctl.ovf = SIGNED && (stage_src.ctl.a_msb == stage_src.ctl.b_msb)
                          && (seg_sum[CHUNK-1] != stage_src.ctl.a_msb);
`ifdef PIPELINED_ADDER_SAT_EN
        if (SIGNED) begin
          if (stage_d.ctl.ovf) stage_d.s = stage_src.ctl.a_msb ? SAT_NEG : SAT_POS;
        end else if (seg_cout) begin
          stage_d.s = '1;
        end
`endif
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      stage_q[gi] <= '0;
      else if (adv) stage_q[gi] <= stage_d;
    end
  end

  assign out_valid = last_q.ctl.valid;
  assign sum       = last_q.s;
  assign carry     = last_q.ctl.carry;
  assign overflow  = last_q.ctl.ovf;

  logic unused_tail;
  assign unused_tail = ^{last_q.a, last_q.b, last_q.ctl.a_msb, last_q.ctl.b_msb};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (unsigned 32/4, signed 32/4, degenerate 16/16).
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Unsigned 32/4 instance
  logic        m_iv, m_ir, m_ov, m_or, m_cin, m_c, m_of;
  logic [31:0] m_a, m_b, m_s;
  // Signed 32/4 instance
  logic        s_iv, s_ir, s_ov, s_or, s_cin, s_c, s_of;
  logic [31:0] s_a, s_b, s_s;
  // Degenerate 16/16 instance
  logic        d_iv, d_ir, d_ov, d_or, d_cin, d_c, d_of;
  logic [15:0] d_a, d_b, d_s;

  pipelined_adder #(.WIDTH(32), .CHUNK(4), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .input_1(m_a), .input_2(m_b),
    .carry_in(m_cin), .out_valid(m_ov), .out_ready(m_or), .sum(m_s), .carry(m_c), .overflow(m_of)
  );

  pipelined_adder #(.WIDTH(32), .CHUNK(4), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .input_1(s_a), .input_2(s_b),
    .carry_in(s_cin), .out_valid(s_ov), .out_ready(s_or), .sum(s_s), .carry(s_c), .overflow(s_of)
  );

  pipelined_adder #(.WIDTH(16), .CHUNK(16), .SIGNED(1'b0)) u_deg (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .input_1(d_a), .input_2(d_b),
    .carry_in(d_cin), .out_valid(d_ov), .out_ready(d_or), .sum(d_s), .carry(d_c), .overflow(d_of)
  );

  // Reference result {carry, overflow, sum}
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input bit sgn);
    logic [32:0] r;
    logic        ovf;
    logic [31:0] s;
    r   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    ovf = sgn && (x[31] == y[31]) && (r[31] != x[31]);
    s   = r[31:0];
`ifdef PIPELINED_ADDER_SAT_EN
    if (sgn && ovf) s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else if (!sgn && r[32]) s = 32'hFFFF_FFFF;
`endif
    return {r[32], ovf, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_iv = 0; m_or = 1; m_a = 0; m_b = 0; m_cin = 0;
    s_iv = 0; s_or = 1; s_a = 0; s_b = 0; s_cin = 0;
    d_iv = 0; d_or = 1; d_a = 0; d_b = 0; d_cin = 0;
    repeat (3) tick();
    total++; if (m_ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", m_ov); end
    total++; if (m_s !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h exp=00000000", m_s); end
    total++; if (m_c !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", m_c); end
    total++; if (m_of !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", m_of); end
    total++; if (d_ov !== 1'b0) begin bad++; $display("FAIL reset_deg_out_valid got=%b exp=0", d_ov); end
    rst = 1'b0;
    tick();
    total++; if (m_ir !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", m_ir); end
    $display("reset: out_valid=%b sum=%h in_ready=%b", m_ov, m_s, m_ir);
  endtask

  task automatic test_wrap();
    int          lat;
    logic [31:0] exp_s;
    exp_s = 32'h0000_0000;
`ifdef PIPELINED_ADDER_SAT_EN
    exp_s = 32'hFFFF_FFFF;
`endif
    m_a = 32'h0000_0001; m_b = 32'hFFFF_FFFF; m_cin = 0; m_iv = 1; m_or = 1;
    total++; if (m_ir !== 1'b1) begin bad++; $display("FAIL wrap_in_ready got=%b exp=1", m_ir); end
    tick();
    m_iv = 0;
    lat = 1;
    while (!m_ov && lat < 20) begin tick(); lat++; end
    total++; if (lat != 8) begin bad++; $display("FAIL wrap_latency got=%0d exp=8", lat); end
    total++; if (m_s !== exp_s) begin bad++; $display("FAIL wrap_sum got=%h exp=%h", m_s, exp_s); end
    total++; if (m_c !== 1'b1) begin bad++; $display("FAIL wrap_carry got=%b exp=1", m_c); end
    total++; if (m_of !== 1'b0) begin bad++; $display("FAIL wrap_overflow got=%b exp=0", m_of); end
    $display("wrap: sum=%h carry=%b latency=%0d", m_s, m_c, lat);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_q[$];
    logic [33:0] e;
    int          got, last_cyc, gaps;
    got = 0; last_cyc = -1; gaps = 0;
    m_or = 1;
    for (int t = 0; t < 40; t++) begin
      if (t < 20) begin
        m_a = $urandom; m_b = $urandom; m_cin = 1'($urandom_range(0, 1)); m_iv = 1;
        exp_q.push_back(ref_add(m_a, m_b, m_cin, 1'b0));
      end else begin
        m_iv = 0;
      end
      tick();
      if (m_ov) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra_result got=%h exp=none", m_s);
        end else begin
          e = exp_q.pop_front();
          if ({m_c, m_of, m_s} !== e) begin
            bad++; $display("FAIL b2b_result%0d got=%h exp=%h", got, {m_c, m_of, m_s}, e);
          end
          $display("b2b: result %0d sum=%h carry=%b cycle=%0d", got, m_s, m_c, t);
        end
        if (last_cyc >= 0 && t != last_cyc + 1) gaps++;
        last_cyc = t;
        got++;
      end
    end
    total++; if (got != 20) begin bad++; $display("FAIL b2b_count got=%0d exp=20", got); end
    total++; if (gaps != 0) begin bad++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_backpressure();
    logic [33:0] bp_exp [3];
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vc [3];
    int          n;
    va[0] = 32'h1234_5678; vb[0] = 32'h1111_1111; vc[0] = 1'b1;
    va[1] = 32'hFFFF_0000; vb[1] = 32'h0001_0000; vc[1] = 1'b0;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vc[2] = 1'b1;
    m_or = 0;
    for (int i = 0; i < 3; i++) begin
      m_a = va[i]; m_b = vb[i]; m_cin = vc[i]; m_iv = 1;
      bp_exp[i] = ref_add(va[i], vb[i], vc[i], 1'b0);
      tick();
    end
    m_iv = 0;
    n = 0;
    while (!m_ov && n < 20) begin tick(); n++; end
    total++; if (m_ov !== 1'b1) begin bad++; $display("FAIL bp_arrival got=%b exp=1", m_ov); end
    // Offer a beat during the stall; it must not be taken.
    m_a = 32'hDEAD_BEEF; m_b = 32'h0BAD_F00D; m_cin = 1; m_iv = 1;
    for (int k = 0; k < 5; k++) begin
      total++; if (m_ir !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b exp=0", k, m_ir); end
      total++;
      if ({m_ov, m_c, m_of, m_s} !== {1'b1, bp_exp[0]}) begin
        bad++; $display("FAIL bp_frozen%0d got=%h exp=%h", k, {m_ov, m_c, m_of, m_s}, {1'b1, bp_exp[0]});
      end
      tick();
    end
    m_iv = 0; m_or = 1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({m_ov, m_c, m_of, m_s} !== {1'b1, bp_exp[i]}) begin
        bad++; $display("FAIL bp_result%0d got=%h exp=%h", i, {m_ov, m_c, m_of, m_s}, {1'b1, bp_exp[i]});
      end
      $display("bp: result %0d sum=%h carry=%b", i, m_s, m_c);
      tick();
    end
    total++; if (m_ov !== 1'b0) begin bad++; $display("FAIL bp_no_extra got=%b exp=0", m_ov); end
  endtask

  task automatic test_signed();
    logic [31:0] ea, eb, ec;
    int          n;
    ea = 32'h8000_0000; eb = 32'h7FFF_FFFF; ec = 32'h0000_0002;
`ifdef PIPELINED_ADDER_SAT_EN
    ea = 32'h7FFF_FFFF; eb = 32'h8000_0000;
`endif
    s_or = 1;
    s_a = 32'h7FFF_FFFF; s_b = 32'h0000_0001; s_cin = 0; s_iv = 1; tick();
    s_a = 32'h8000_0000; s_b = 32'hFFFF_FFFF; s_cin = 0; tick();
    s_a = 32'h0000_0005; s_b = 32'hFFFF_FFFD; s_cin = 0; tick();
    s_iv = 0;
    n = 0;
    while (!s_ov && n < 20) begin tick(); n++; end
    total++;
    if ({s_ov, s_c, s_of, s_s} !== {1'b1, 1'b0, 1'b1, ea}) begin
      bad++; $display("FAIL sgn_pos_ovf got=%h exp=%h", {s_ov, s_c, s_of, s_s}, {1'b1, 1'b0, 1'b1, ea});
    end
    $display("signed: 7fffffff+1 sum=%h ovf=%b", s_s, s_of);
    tick();
    total++;
    if ({s_ov, s_c, s_of, s_s} !== {1'b1, 1'b1, 1'b1, eb}) begin
      bad++; $display("FAIL sgn_neg_ovf got=%h exp=%h", {s_ov, s_c, s_of, s_s}, {1'b1, 1'b1, 1'b1, eb});
    end
    $display("signed: 80000000+ffffffff sum=%h ovf=%b", s_s, s_of);
    tick();
    total++;
    if ({s_ov, s_c, s_of, s_s} !== {1'b1, 1'b1, 1'b0, ec}) begin
      bad++; $display("FAIL sgn_no_ovf got=%h exp=%h", {s_ov, s_c, s_of, s_s}, {1'b1, 1'b1, 1'b0, ec});
    end
    $display("signed: 5+fffffffd sum=%h ovf=%b", s_s, s_of);
    tick();
  endtask

  task automatic test_reset_midflight();
    int stale, lat;
    m_or = 1;
    for (int i = 0; i < 4; i++) begin
      m_a = 32'h0101_0101 * (i + 1); m_b = 32'h5555_5555; m_cin = 1; m_iv = 1;
      tick();
    end
    m_iv = 0;
    rst = 1'b1;
    #1;
    total++; if (m_ov !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", m_ov); end
    total++; if (m_s !== 32'h0) begin bad++; $display("FAIL rstmid_sum got=%h exp=00000000", m_s); end
    tick();
    rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (m_ov) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
    m_a = 32'h0000_00FF; m_b = 32'h0000_0001; m_cin = 0; m_iv = 1;
    tick();
    m_iv = 0;
    lat = 1;
    while (!m_ov && lat < 20) begin tick(); lat++; end
    total++; if (lat != 8) begin bad++; $display("FAIL rstmid_latency got=%0d exp=8", lat); end
    total++; if (m_s !== 32'h0000_0100) begin bad++; $display("FAIL rstmid_sum_new got=%h exp=00000100", m_s); end
    $display("rstmid: new sum=%h latency=%0d", m_s, lat);
    tick();
  endtask

  task automatic test_degenerate();
    int          lat;
    logic [15:0] exp_s;
    exp_s = 16'h0001;
`ifdef PIPELINED_ADDER_SAT_EN
    exp_s = 16'hFFFF;
`endif
    d_or = 1;
    d_a = 16'h8000; d_b = 16'h8000; d_cin = 1; d_iv = 1;
    tick();
    d_iv = 0;
    lat = 1;
    while (!d_ov && lat < 20) begin tick(); lat++; end
    total++; if (lat != 1) begin bad++; $display("FAIL deg_latency got=%0d exp=1", lat); end
    total++; if (d_s !== exp_s) begin bad++; $display("FAIL deg_sum got=%h exp=%h", d_s, exp_s); end
    total++; if (d_c !== 1'b1) begin bad++; $display("FAIL deg_carry got=%b exp=1", d_c); end
    total++; if (d_of !== 1'b0) begin bad++; $display("FAIL deg_overflow got=%b exp=0", d_of); end
    $display("deg: sum=%h carry=%b latency=%0d", d_s, d_c, lat);
    tick();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_signed();
    test_reset_midflight();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
